// File: rtl/count8dn_fsm_if.sv
// count8dn_fsm_if
//   Groups the control and status signals of the loadable down-counter.
//   master : drives EN, load, CNT_In; observes CNT, TC, ZERO, BUSY
//   slave  : the counter itself (inverse directions)
//   Signals:
//     EN     count enable, only honoured in RUN
//     load   synchronous load strobe, wins over EN
//     CNT_In load value
//     CNT    registered current count
//     TC     registered one-cycle terminal-count pulse
//     ZERO   CNT == 0
//     BUSY   counter is in RUN
interface count8dn_fsm_if #(
  parameter int WIDTH = 8
);
  logic             EN;
  logic             load;
  logic [WIDTH-1:0] CNT_In;
  logic [WIDTH-1:0] CNT;
  logic             TC;
  logic             ZERO;
  logic             BUSY;

  modport master (
    output EN, load, CNT_In,
    input  CNT, TC, ZERO, BUSY
  );

  modport slave (
    input  EN, load, CNT_In,
    output CNT, TC, ZERO, BUSY
  );
endinterface

// File: rtl/count8dn_fsm.sv
// count8dn_fsm
//   Loadable down-counter with an explicit IDLE/RUN/DONE state machine.
//   A non-zero load starts a count towards zero; the edge that leaves 1
//   raises a one-cycle TC pulse. One-shot mode parks in DONE with CNT=0;
//   auto-reload mode reloads the last loaded value and keeps running, so
//   it acts as a periodic tick generator.
//   Ports:
//     clk  rising-edge clock
//     res  asynchronous active-low reset
//     bus  count8dn_fsm_if.slave (EN, load, CNT_In in; CNT, TC, ZERO, BUSY out)
//   Parameters:
//     WIDTH       counter width in bits
//     AUTO_RELOAD 0 = one-shot, 1 = reload on terminal count
module count8dn_fsm #(
  parameter int WIDTH       = 8,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input logic             clk,
  input logic             res,
  count8dn_fsm_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_r, state_s;
  logic [WIDTH-1:0] cnt_r,   cnt_s;
  logic [WIDTH-1:0] rld_r,   rld_s;
  logic             tc_r,    tc_s;

  // State, count, reload value and TC registers.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      rld_r   <= CNT_ZERO;
      tc_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      rld_r   <= rld_s;
      tc_r    <= tc_s;
    end
  end

  // Next-state logic: load beats enable, enable beats hold.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    rld_s   = rld_r;
    tc_s    = 1'b0;
    if (bus.load) begin
      // A load of zero lands in IDLE so RUN never holds CNT=0, which
      // keeps the decrement from ever wrapping to all-ones.
      cnt_s   = bus.CNT_In;
      rld_s   = bus.CNT_In;
      state_s = (bus.CNT_In != CNT_ZERO) ? RUN : IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = IDLE;
        end
        RUN: begin
          if (bus.EN) begin
            if (cnt_r == CNT_ONE) begin
              tc_s = 1'b1;
              if (AUTO_RELOAD) begin
                // RLD is non-zero here: RUN is only entered by a non-zero load.
                cnt_s   = rld_r;
                state_s = RUN;
              end else begin
                cnt_s   = CNT_ZERO;
                state_s = DONE;
              end
            end else begin
              cnt_s = cnt_r - CNT_ONE;
            end
          end else begin
            state_s = RUN;
          end
        end
        DONE: begin
          state_s = DONE;
        end
        default: begin
          // Unreachable encoding: fall back to the reset state.
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
          rld_s   = CNT_ZERO;
        end
      endcase
    end
  end

  assign bus.CNT  = cnt_r;
  assign bus.TC   = tc_r;
  assign bus.ZERO = (cnt_r == CNT_ZERO);
  assign bus.BUSY = (state_r == RUN);

endmodule
